umt_entry_sequencer: RTL and testbench

Sequences UMT entry writes onto the physical match tiles (PMTs). Sits between the UMT CSR interface and the PMT array. Holds a per-UMT geometry table programmed by config pulses and buffers entry-write pulses in a small FIFO. Splits each 64-bit entry/mask into PMT-width slices issued one at a time over a valid/ready write port.

---
 rtl/umt_entry_sequencer_if.sv | 35 +++
 rtl/umt_entry_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_umt_entry_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/umt_entry_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : umt_entry_sequencer_if
// Brief  : Valid/ready PMT slice-write port between sequencer and PMT array.
// Rev    : 1.0  initial release
// ============================================================================
interface umt_entry_sequencer_if #(
    parameter int PMT_WIDTH = 16
);
    logic                 pmt_wr_valid;
    logic                 pmt_wr_ready;
    logic [7:0]           pmt_wr_id;
    logic [8:0]           pmt_wr_addr;
    logic [PMT_WIDTH-1:0] pmt_wr_data;
    logic [PMT_WIDTH-1:0] pmt_wr_mask;

    modport master (
        output pmt_wr_valid,
        output pmt_wr_id,
        output pmt_wr_addr,
        output pmt_wr_data,
        output pmt_wr_mask,
        input  pmt_wr_ready
    );

    modport slave (
        input  pmt_wr_valid,
        input  pmt_wr_id,
        input  pmt_wr_addr,
        input  pmt_wr_data,
        input  pmt_wr_mask,
        output pmt_wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/umt_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module : umt_entry_sequencer
// Brief  : Buffers UMT entry writes and issues them as PMT-width slice writes.
// Rev    : 1.0  initial release
// ============================================================================
module umt_entry_sequencer #(
    parameter int NUM_UMT    = 8,
    parameter int PMT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,

    input  wire logic                       cfg_valid_i,
    input  wire logic                       cfg_wr_en_i,
    input  wire logic [$clog2(NUM_UMT)-1:0] cfg_id_i,
    input  wire logic [15:0]                cfg_width_i,
    input  wire logic [15:0]                cfg_depth_i,
    input  wire logic [7:0]                 cfg_base_pmt_i,

    input  wire logic                       entry_valid_i,
    input  wire logic [$clog2(NUM_UMT)-1:0] entry_umt_id_i,
    input  wire logic [8:0]                 entry_addr_i,
    input  wire logic [63:0]                entry_data_i,
    input  wire logic [63:0]                entry_mask_i,

    umt_entry_sequencer_if.master           pmt,

    output logic                            busy_o,
    output logic                            cfg_err_o,
    output logic                            entry_err_o,
    output logic                            ovf_err_o,
    input  wire logic                       err_clear_i,
    output logic [15:0]                     wr_count_o
);

    localparam int ID_W     = $clog2(NUM_UMT);
    localparam int SLICE_SH = $clog2(PMT_WIDTH);
    localparam int SL_W     = 7 - SLICE_SH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int ENT_W    = ID_W + 9 + 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Geometry table
    // ------------------------------------------------------------------
    logic [NUM_UMT-1:0] tbl_valid_q;
    logic [6:0]         tbl_width_q [NUM_UMT];
    logic [9:0]         tbl_depth_q [NUM_UMT];
    logic [7:0]         tbl_base_q  [NUM_UMT];

    logic w_cfg_legal;
    logic w_cfg_wr;
    logic w_cfg_bad;

    assign w_cfg_legal = (cfg_width_i != 16'd0) && (cfg_width_i <= 16'd64) &&
                         (cfg_depth_i != 16'd0) && (cfg_depth_i <= 16'd512);
    assign w_cfg_wr    = cfg_valid_i & cfg_wr_en_i & w_cfg_legal;
    assign w_cfg_bad   = cfg_valid_i & cfg_wr_en_i & ~w_cfg_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < NUM_UMT; i++) begin
                tbl_width_q[i] <= '0;
                tbl_depth_q[i] <= '0;
                tbl_base_q[i]  <= '0;
            end
        end else if (w_cfg_wr) begin
            tbl_valid_q[cfg_id_i] <= 1'b1;
            tbl_width_q[cfg_id_i] <= cfg_width_i[6:0];
            tbl_depth_q[cfg_id_i] <= cfg_depth_i[9:0];
            tbl_base_q[cfg_id_i]  <= cfg_base_pmt_i;
        end
    end

    // ------------------------------------------------------------------
    // Entry FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_fifo_head;

    state_t state_q;

    assign w_fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign w_fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign w_push       = entry_valid_i & ~w_fifo_full;
    assign w_pop        = (state_q == S_IDLE) & ~w_fifo_empty;
    assign w_fifo_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {entry_umt_id_i, entry_addr_i,
                                                entry_mask_i, entry_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------
    // Slice sequencer
    // ------------------------------------------------------------------
    logic [ID_W-1:0]      ent_id_q;
    logic [8:0]           ent_addr_q;
    logic [63:0]          ent_data_q;
    logic [63:0]          ent_mask_q;
    logic [7:0]           base_q;
    logic [SL_W-1:0]      slice_q;
    logic [SL_W-1:0]      last_q;
    logic                 pmt_valid_q;
    logic [7:0]           pmt_id_q;
    logic [8:0]           pmt_addr_q;
    logic [PMT_WIDTH-1:0] pmt_data_q;
    logic [PMT_WIDTH-1:0] pmt_mask_q;
    logic [15:0]          wr_count_q;

    logic [6:0]           w_row_width;
    logic [9:0]           w_row_depth;
    logic [7:0]           w_row_base;
    logic [6:0]           w_row_wm1;
    logic [SL_W-1:0]      w_row_last;
    logic                 w_load_bad;
    logic [SL_W-1:0]      w_slice_nxt;
    logic [7:0]           w_slice_nxt_ext;

    assign w_row_width = tbl_width_q[ent_id_q];
    assign w_row_depth = tbl_depth_q[ent_id_q];
    assign w_row_base  = tbl_base_q[ent_id_q];
    // Last slice index = (width-1) / PMT_WIDTH; avoids a ceil-divide adder.
    assign w_row_wm1   = w_row_width - 7'd1;
    assign w_row_last  = w_row_wm1[6:SLICE_SH];
    assign w_load_bad  = (state_q == S_LOAD) &&
                         (!tbl_valid_q[ent_id_q] || ({1'b0, ent_addr_q} >= w_row_depth));

    assign w_slice_nxt     = slice_q + {{(SL_W-1){1'b0}}, 1'b1};
    assign w_slice_nxt_ext = {{(8-SL_W){1'b0}}, w_slice_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ent_id_q    <= '0;
            ent_addr_q  <= '0;
            ent_data_q  <= '0;
            ent_mask_q  <= '0;
            base_q      <= '0;
            slice_q     <= '0;
            last_q      <= '0;
            pmt_valid_q <= 1'b0;
            pmt_id_q    <= '0;
            pmt_addr_q  <= '0;
            pmt_data_q  <= '0;
            pmt_mask_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        {ent_id_q, ent_addr_q, ent_mask_q, ent_data_q} <= w_fifo_head;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_load_bad) begin
                        state_q <= S_IDLE;
                    end else begin
                        base_q      <= w_row_base;
                        last_q      <= w_row_last;
                        slice_q     <= '0;
                        pmt_valid_q <= 1'b1;
                        pmt_id_q    <= w_row_base;
                        pmt_addr_q  <= ent_addr_q;
                        pmt_data_q  <= ent_data_q[PMT_WIDTH-1:0];
                        pmt_mask_q  <= ent_mask_q[PMT_WIDTH-1:0];
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pmt.pmt_wr_ready) begin
                        if (slice_q == last_q) begin
                            pmt_valid_q <= 1'b0;
                            wr_count_q  <= wr_count_q + 16'd1;
                            state_q     <= S_IDLE;
                        end else begin
                            // Entry words shift down so the next slice is always at a fixed offset.
                            slice_q    <= w_slice_nxt;
                            pmt_id_q   <= base_q + w_slice_nxt_ext;
                            pmt_data_q <= ent_data_q[2*PMT_WIDTH-1:PMT_WIDTH];
                            pmt_mask_q <= ent_mask_q[2*PMT_WIDTH-1:PMT_WIDTH];
                            ent_data_q <= ent_data_q >> PMT_WIDTH;
                            ent_mask_q <= ent_mask_q >> PMT_WIDTH;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky errors: a new error in the clearing cycle keeps the flag set
    // ------------------------------------------------------------------
    logic cfg_err_q;
    logic entry_err_q;
    logic ovf_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q   <= 1'b0;
            entry_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            cfg_err_q   <= (cfg_err_q   & ~err_clear_i) | w_cfg_bad;
            entry_err_q <= (entry_err_q & ~err_clear_i) | w_load_bad;
            ovf_err_q   <= (ovf_err_q   & ~err_clear_i) | (entry_valid_i & w_fifo_full);
        end
    end

    assign pmt.pmt_wr_valid = pmt_valid_q;
    assign pmt.pmt_wr_id    = pmt_id_q;
    assign pmt.pmt_wr_addr  = pmt_addr_q;
    assign pmt.pmt_wr_data  = pmt_data_q;
    assign pmt.pmt_wr_mask  = pmt_mask_q;

    assign busy_o      = !w_fifo_empty || (state_q != S_IDLE);
    assign cfg_err_o   = cfg_err_q;
    assign entry_err_o = entry_err_q;
    assign ovf_err_o   = ovf_err_q;
    assign wr_count_o  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_umt_entry_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_umt_entry_sequencer
// Brief  : Directed vector table plus stall, overflow and reset sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_umt_entry_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_wr_en;
    logic [2:0]  cfg_id;
    logic [15:0] cfg_width, cfg_depth;
    logic [7:0]  cfg_base_pmt;
    logic        entry_valid;
    logic [2:0]  entry_umt_id;
    logic [8:0]  entry_addr;
    logic [63:0] entry_data, entry_mask;
    logic        busy, cfg_err, entry_err, ovf_err, err_clear;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    umt_entry_sequencer_if #(.PMT_WIDTH(16)) pmt_if ();

    umt_entry_sequencer #(.NUM_UMT(8), .PMT_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_wr_en_i    (cfg_wr_en),
        .cfg_id_i       (cfg_id),
        .cfg_width_i    (cfg_width),
        .cfg_depth_i    (cfg_depth),
        .cfg_base_pmt_i (cfg_base_pmt),
        .entry_valid_i  (entry_valid),
        .entry_umt_id_i (entry_umt_id),
        .entry_addr_i   (entry_addr),
        .entry_data_i   (entry_data),
        .entry_mask_i   (entry_mask),
        .pmt            (pmt_if),
        .busy_o         (busy),
        .cfg_err_o      (cfg_err),
        .entry_err_o    (entry_err),
        .ovf_err_o      (ovf_err),
        .err_clear_i    (err_clear),
        .wr_count_o     (wr_count)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [8:0]  addr;
        logic [15:0] data;
        logic [15:0] mask;
    } wr_t;

    wr_t wq[$];

    // Handshake is committed at the posedge following this sample.
    always @(negedge clk) begin
        if (rst_n && pmt_if.pmt_wr_valid && pmt_if.pmt_wr_ready) begin
            wq.push_back({pmt_if.pmt_wr_id, pmt_if.pmt_wr_addr, pmt_if.pmt_wr_data, pmt_if.pmt_wr_mask});
        end
    end

    // Field order: do_cfg, cfg_wr_en, cfg_id, width, depth, base,
    //              ent_id, ent_addr, ent_data, ent_mask,
    //              exp_n, exp_id (slice0 in low byte), exp_data, exp_mask, exp_cfg_err, exp_entry_err
    typedef struct {
        bit          do_cfg;
        bit          cfg_wr_en;
        logic [2:0]  cfg_id;
        logic [15:0] cfg_width;
        logic [15:0] cfg_depth;
        logic [7:0]  cfg_base;
        logic [2:0]  ent_id;
        logic [8:0]  ent_addr;
        logic [63:0] ent_data;
        logic [63:0] ent_mask;
        int          exp_n;
        logic [3:0][7:0]  exp_id;
        logic [3:0][15:0] exp_data;
        logic [3:0][15:0] exp_mask;
        bit          exp_cfg_err;
        bit          exp_entry_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int k = 0;
        while (busy && k < maxc) begin
            tick();
            k++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic send_entry(input logic [2:0] id, input logic [8:0] addr,
                              input logic [63:0] data, input logic [63:0] mask);
        entry_valid  = 1'b1;
        entry_umt_id = id;
        entry_addr   = addr;
        entry_data   = data;
        entry_mask   = mask;
        tick();
        entry_valid  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1, 1, 3'd2, 16'd40, 16'd512, 8'd10, 3'd2, 9'd5, 64'h1122_3344_5566_7788, '1,
                     3, 32'h000C_0B0A, 64'h0000_3344_5566_7788, 64'h0000_FFFF_FFFF_FFFF, 0, 0};
        vecs[1]  = '{0, 0, 3'd0, 16'd0, 16'd0, 8'd0, 3'd5, 9'd0, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 0, 1};
        vecs[2]  = '{1, 1, 3'd0, 16'd16, 16'd16, 8'd0, 3'd0, 9'd16, 64'h5, 64'hF,
                     0, 32'h0, 64'h0, 64'h0, 0, 1};
        vecs[3]  = '{0, 0, 3'd0, 16'd0, 16'd0, 8'd0, 3'd0, 9'd15, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0F0F,
                     1, 32'h0, 64'hDDDD, 64'h0F0F, 0, 0};
        vecs[4]  = '{1, 1, 3'd7, 16'd64, 16'd1, 8'd254, 3'd7, 9'd0, 64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_00FF_00FF,
                     4, 32'h0100_FFFE, 64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_00FF_00FF, 0, 0};
        vecs[5]  = '{1, 1, 3'd3, 16'd0, 16'd16, 8'd0, 3'd3, 9'd0, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 1, 1};
        vecs[6]  = '{1, 1, 3'd4, 16'd65, 16'd8, 8'd0, 3'd4, 9'd0, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 1, 1};
        vecs[7]  = '{1, 1, 3'd1, 16'd17, 16'd2, 8'd100, 3'd1, 9'd1, 64'h0000_0000_FFFF_1234, 64'h0000_0000_0001_8000,
                     2, 32'h0000_6564, 64'h0000_0000_FFFF_1234, 64'h0000_0000_0001_8000, 0, 0};
        vecs[8]  = '{1, 0, 3'd6, 16'd16, 16'd4, 8'd0, 3'd6, 9'd0, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 0, 1};
        vecs[9]  = '{0, 0, 3'd0, 16'd0, 16'd0, 8'd0, 3'd2, 9'd511, 64'h0, 64'h0,
                     3, 32'h000C_0B0A, 64'h0, 64'h0, 0, 0};
        vecs[10] = '{1, 1, 3'd5, 16'd8, 16'd513, 8'd0, 3'd5, 9'd0, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 1, 1};
        vecs[11] = '{1, 1, 3'd5, 16'd1, 16'd1, 8'd3, 3'd5, 9'd0, 64'hFFFF, 64'h1,
                     1, 32'h0000_0003, 64'hFFFF, 64'h1, 0, 0};
        vecs[12] = '{0, 0, 3'd0, 16'd0, 16'd0, 8'd0, 3'd5, 9'd1, 64'h1, 64'h1,
                     0, 32'h0, 64'h0, 64'h0, 0, 1};

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_wr_en = 1'b0; cfg_id = '0;
        cfg_width = '0; cfg_depth = '0; cfg_base_pmt = '0; entry_valid = 1'b0;
        entry_umt_id = '0; entry_addr = '0; entry_data = '0; entry_mask = '0;
        err_clear = 1'b0; pmt_if.pmt_wr_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst.valid", {63'd0, pmt_if.pmt_wr_valid}, 64'd0);
        check("rst.id",    {56'd0, pmt_if.pmt_wr_id}, 64'd0);
        check("rst.addr",  {55'd0, pmt_if.pmt_wr_addr}, 64'd0);
        check("rst.data",  {32'd0, pmt_if.pmt_wr_data, pmt_if.pmt_wr_mask}, 64'd0);
        check("rst.flags", {59'd0, busy, cfg_err, entry_err, ovf_err, 1'b0}, 64'd0);
        check("rst.count", {48'd0, wr_count}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            logic [15:0] cnt0;
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            if (vecs[i].do_cfg) begin
                cfg_valid    = 1'b1;
                cfg_wr_en    = vecs[i].cfg_wr_en;
                cfg_id       = vecs[i].cfg_id;
                cfg_width    = vecs[i].cfg_width;
                cfg_depth    = vecs[i].cfg_depth;
                cfg_base_pmt = vecs[i].cfg_base;
                tick();
                cfg_valid = 1'b0;
                cfg_wr_en = 1'b0;
            end
            wq.delete();
            cnt0 = wr_count;
            send_entry(vecs[i].ent_id, vecs[i].ent_addr, vecs[i].ent_data, vecs[i].ent_mask);
            wait_idle(40, $sformatf("v%0d.idle", i));
            check($sformatf("v%0d.nwr", i), 64'(wq.size()), 64'(vecs[i].exp_n));
            for (int j = 0; j < vecs[i].exp_n && j < wq.size(); j++) begin
                check($sformatf("v%0d.id%0d", i, j),   {56'd0, wq[j].id},   {56'd0, vecs[i].exp_id[j]});
                check($sformatf("v%0d.addr%0d", i, j), {55'd0, wq[j].addr}, {55'd0, vecs[i].ent_addr});
                check($sformatf("v%0d.data%0d", i, j), {48'd0, wq[j].data}, {48'd0, vecs[i].exp_data[j]});
                check($sformatf("v%0d.mask%0d", i, j), {48'd0, wq[j].mask}, {48'd0, vecs[i].exp_mask[j]});
            end
            check($sformatf("v%0d.cfg_err", i),   {63'd0, cfg_err},   {63'd0, vecs[i].exp_cfg_err});
            check($sformatf("v%0d.entry_err", i), {63'd0, entry_err}, {63'd0, vecs[i].exp_entry_err});
            check($sformatf("v%0d.count", i), {48'd0, 16'(wr_count - cnt0)},
                  (vecs[i].exp_n > 0) ? 64'd1 : 64'd0);
        end

        // Latency: pulse captured at edge T, valid observed after edge T+2 (cycle T+3)
        begin
            int first = 0;
            entry_valid = 1'b1; entry_umt_id = 3'd2; entry_addr = 9'd7;
            entry_data = 64'h1122_3344_5566_7788; entry_mask = '1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (k == 1) entry_valid = 1'b0;
                if (pmt_if.pmt_wr_valid && first == 0) first = k;
            end
            check("lat.first_valid", 64'(first), 64'd3);
            wait_idle(20, "lat.idle");
        end

        // Ready stall during slice 1
        begin
            logic [15:0] cnt0;
            int k;
            wq.delete();
            cnt0 = wr_count;
            pmt_if.pmt_wr_ready = 1'b0;
            send_entry(3'd2, 9'd5, 64'h1122_3344_5566_7788, '1);
            k = 0;
            while (!pmt_if.pmt_wr_valid && k < 10) begin tick(); k++; end
            check("stall.valid", {63'd0, pmt_if.pmt_wr_valid}, 64'd1);
            check("stall.id0", {56'd0, pmt_if.pmt_wr_id}, 64'd10);
            pmt_if.pmt_wr_ready = 1'b1;
            tick();
            pmt_if.pmt_wr_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
                tick();
                check($sformatf("stall.hold%0d", s),
                      {23'd0, pmt_if.pmt_wr_valid, pmt_if.pmt_wr_id, pmt_if.pmt_wr_data, pmt_if.pmt_wr_mask},
                      {23'd0, 1'b1, 8'd11, 16'h5566, 16'hFFFF});
            end
            check("stall.count_hold", {48'd0, 16'(wr_count - cnt0)}, 64'd0);
            pmt_if.pmt_wr_ready = 1'b1;
            wait_idle(20, "stall.idle");
            check("stall.nwr", 64'(wq.size()), 64'd3);
            if (wq.size() == 3) begin
                check("stall.ids", {40'd0, wq[0].id, wq[1].id, wq[2].id}, {40'd0, 8'd10, 8'd11, 8'd12});
                check("stall.data", {16'd0, wq[0].data, wq[1].data, wq[2].data}, 64'h0000_7788_5566_3344);
            end
            check("stall.count", {48'd0, 16'(wr_count - cnt0)}, 64'd1);
        end

        // Overflow: 6 back-to-back pulses with PMT stalled
        begin
            logic [15:0] cnt0;
            err_clear = 1'b1; tick(); err_clear = 1'b0;
            wq.delete();
            cnt0 = wr_count;
            pmt_if.pmt_wr_ready = 1'b0;
            for (int k = 0; k < 6; k++) begin
                entry_valid = 1'b1; entry_umt_id = 3'd0; entry_addr = 9'(k);
                entry_data = 64'(k + 1); entry_mask = 64'h0;
                tick();
            end
            entry_valid = 1'b0;
            check("ovf.err", {63'd0, ovf_err}, 64'd1);
            check("ovf.busy", {63'd0, busy}, 64'd1);
            check("ovf.head", {47'd0, pmt_if.pmt_wr_valid, pmt_if.pmt_wr_addr, 7'd0}, {47'd0, 1'b1, 9'd0, 7'd0});
            pmt_if.pmt_wr_ready = 1'b1;
            wait_idle(100, "ovf.idle");
            check("ovf.nwr", 64'(wq.size()), 64'd5);
            for (int k = 0; k < 5 && k < wq.size(); k++) begin
                check($sformatf("ovf.wr%0d", k), {23'd0, wq[k].addr, wq[k].data, wq[k].id},
                      {23'd0, 9'(k), 16'(k + 1), 8'd0});
            end
            check("ovf.count", {48'd0, 16'(wr_count - cnt0)}, 64'd5);
        end

        // Clearing, and a new error in the clearing cycle
        begin
            send_entry(3'd6, 9'd0, 64'h0, 64'h0);
            wait_idle(20, "clr.idle");
            check("clr.pre", {61'd0, cfg_err, entry_err, ovf_err}, 64'b011);
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            check("clr.all", {61'd0, cfg_err, entry_err, ovf_err}, 64'd0);
            err_clear = 1'b1; cfg_valid = 1'b1; cfg_wr_en = 1'b1; cfg_id = 3'd6;
            cfg_width = 16'd0; cfg_depth = 16'd4;
            tick();
            err_clear = 1'b0; cfg_valid = 1'b0; cfg_wr_en = 1'b0;
            check("clr.err_wins", {63'd0, cfg_err}, 64'd1);
        end

        // Asynchronous reset during ISSUE
        begin
            int k;
            wq.delete();
            pmt_if.pmt_wr_ready = 1'b0;
            send_entry(3'd2, 9'd3, 64'h0, 64'h0);
            send_entry(3'd2, 9'd4, 64'h0, 64'h0);
            k = 0;
            while (!pmt_if.pmt_wr_valid && k < 10) begin tick(); k++; end
            check("arst.pre_valid", {63'd0, pmt_if.pmt_wr_valid}, 64'd1);
            #2 rst_n = 1'b0;
            #1;
            check("arst.valid", {63'd0, pmt_if.pmt_wr_valid}, 64'd0);
            check("arst.state", {47'd0, busy, wr_count}, 64'd0);
            tick();
            rst_n = 1'b1;
            pmt_if.pmt_wr_ready = 1'b1;
            repeat (8) tick();
            check("arst.lost", 64'(wq.size()), 64'd0);
            check("arst.busy", {63'd0, busy}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
